// File: rtl/data_mem_stage.sv
// Single-port data memory stage with fixed wait states and a one-cycle response strobe.
// Define DMEM_RANGE_CHECK_EN to flag out-of-range addresses instead of wrapping the index.
module data_mem_stage #(
    parameter int          DATA_W    = 32,
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'd1024,
    parameter int          WAIT_CYC  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic              lat_we;
    logic [31:0]       lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              acc_we;
    logic [31:0]       acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [AW-1:0]     acc_idx;
    logic              addr_ok;
    logic              enter_resp;
    logic [DATA_W-1:0] rdata_next;

    // With zero wait states the access happens on the accept edge, so the raw request
    // is used before the latched copy exists.
    always_comb begin
        acc_we     = (state == IDLE) ? req_we    : lat_we;
        acc_addr   = (state == IDLE) ? req_addr  : lat_addr;
        acc_wdata  = (state == IDLE) ? req_wdata : lat_wdata;
        acc_idx    = AW'((acc_addr - BASE_ADDR) >> 2);
`ifdef DMEM_RANGE_CHECK_EN
        addr_ok    = (acc_addr >= BASE_ADDR) &&
                     ({1'b0, acc_addr} < (33'(BASE_ADDR) + 33'(4 * DEPTH)));
`else
        addr_ok    = 1'b1;
`endif
        enter_resp = ((state == IDLE) && req_valid && (WAIT_CYC == 0)) ||
                     ((state == WAIT) && (cnt == 4'd1));
        rdata_next = (acc_we || !addr_ok) ? '0 : mem[acc_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= DATA_W'(i);
        end else if (enter_resp && acc_we && addr_ok) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    // All handshake outputs are registered alongside the state so they change only on edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        cnt       <= 4'(WAIT_CYC);
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (enter_resp) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= rdata_next;
                            resp_err   <= !addr_ok;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (enter_resp) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= rdata_next;
                        resp_err   <= !addr_ok;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                    busy       <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    cnt        <= 4'd0;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_stage.sv
// Directed bench for data_mem_stage: a WAIT_CYC=2 instance and a WAIT_CYC=0 instance.
// Expected results for out-of-range accesses follow DMEM_RANGE_CHECK_EN.
module tb_data_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    logic        z_valid = 1'b0;
    logic        z_ready;
    logic        z_we = 1'b0;
    logic [31:0] z_addr = '0;
    logic [31:0] z_wdata = '0;
    logic        z_resp_valid;
    logic [31:0] z_rdata;
    logic        z_err;
    logic        z_busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    data_mem_stage #(.DATA_W(32), .DEPTH(64), .BASE_ADDR(32'd1024), .WAIT_CYC(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
    );

    data_mem_stage #(.DATA_W(32), .DEPTH(64), .BASE_ADDR(32'd1024), .WAIT_CYC(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(z_valid), .req_ready(z_ready),
        .req_we(z_we), .req_addr(z_addr), .req_wdata(z_wdata),
        .resp_valid(z_resp_valid), .resp_rdata(z_rdata), .resp_err(z_err), .busy(z_busy)
    );

    // Issues one request on the WAIT_CYC=2 instance and reports the cycle of the response
    // (1 = first cycle after the accept edge), or -1 if none arrives within the bound.
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             output int lat, output logic [31:0] rdata, output logic err,
                             output logic busy_ok);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = -1;
        rdata = '0;
        err = 1'b0;
        busy_ok = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (resp_valid === 1'b1) begin
                lat = i;
                rdata = resp_rdata;
                err = resp_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors += 6;
        if (req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready got %b want 1", req_ready); end
        if (resp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid got %b want 0", resp_valid); end
        if (resp_rdata !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_rdata got %h want 0", resp_rdata); end
        if (resp_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err got %b want 0", resp_err); end
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        if (z_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready0 got %b want 1", z_ready); end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_load();
        int lat; logic [31:0] rd; logic er; logic bok;
        do_access(1'b0, 32'd1024 + 32'd20, '0, lat, rd, er, bok);
        vectors += 3;
        if (lat != 3) begin miscompares++; $display("[TB] FAIL load5_latency got %0d want 3", lat); end
        if (rd !== 32'd5) begin miscompares++; $display("[TB] FAIL load5_rdata got %h want 5", rd); end
        if (er !== 1'b0) begin miscompares++; $display("[TB] FAIL load5_err got %b want 0", er); end
        do_access(1'b0, 32'd1024 + 32'd252, '0, lat, rd, er, bok);
        vectors += 1;
        if (rd !== 32'd63) begin miscompares++; $display("[TB] FAIL load63_rdata got %h want 3f", rd); end
        @(negedge clk);
        vectors += 2;
        if (resp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL strobe_width got %b want 0", resp_valid); end
        if (resp_rdata !== 32'd0) begin miscompares++; $display("[TB] FAIL idle_rdata got %h want 0", resp_rdata); end
    endtask

    task automatic test_store_load();
        int lat; logic [31:0] rd; logic er; logic bok;
        do_access(1'b1, 32'd1032, 32'hDEADBEEF, lat, rd, er, bok);
        vectors += 3;
        if (lat != 3) begin miscompares++; $display("[TB] FAIL store_latency got %0d want 3", lat); end
        if (rd !== 32'd0) begin miscompares++; $display("[TB] FAIL store_rdata got %h want 0", rd); end
        if (bok !== 1'b1) begin miscompares++; $display("[TB] FAIL store_busy got %b want 1", bok); end
        do_access(1'b0, 32'd1035, '0, lat, rd, er, bok);
        vectors += 2;
        if (rd !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL unaligned_load got %h want deadbeef", rd); end
        if (bok !== 1'b1) begin miscompares++; $display("[TB] FAIL load_busy got %b want 1", bok); end
    endtask

    // WAIT_CYC=0: with req_valid held high the instance alternates accept / respond.
    task automatic test_back_to_back();
        int responses = 0;
        @(negedge clk);
        z_valid = 1'b1;
        z_we    = 1'b0;
        z_addr  = 32'd1024 + 32'd28;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vectors += 2;
            if (z_resp_valid !== ((i % 2) == 0)) begin
                miscompares++;
                $display("[TB] FAIL b2b_valid[%0d] got %b want %b", i, z_resp_valid, (i % 2) == 0);
            end
            if (z_ready !== ((i % 2) == 1)) begin
                miscompares++;
                $display("[TB] FAIL b2b_ready[%0d] got %b want %b", i, z_ready, (i % 2) == 1);
            end
            if (z_resp_valid === 1'b1) begin
                responses++;
                vectors += 1;
                if (z_rdata !== 32'd7) begin miscompares++; $display("[TB] FAIL b2b_rdata[%0d] got %h want 7", i, z_rdata); end
            end
        end
        vectors += 1;
        if (responses != 4) begin miscompares++; $display("[TB] FAIL b2b_count got %0d want 4", responses); end
        z_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int lat; logic [31:0] rd; logic er; logic bok;
        logic seen = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'd1024;
        req_wdata = 32'h1234;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        vectors += 2;
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_busy got %b want 0", busy); end
        if (req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL abort_ready got %b want 1", req_ready); end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) seen = 1'b1;
        end
        vectors += 1;
        if (seen !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_response got %b want 0", seen); end
        do_access(1'b0, 32'd1024, '0, lat, rd, er, bok);
        vectors += 1;
        if (rd !== 32'd0) begin miscompares++; $display("[TB] FAIL abort_store got %h want 0", rd); end
    endtask

    task automatic test_range();
        int lat; logic [31:0] rd; logic er; logic bok;
        logic        exp_err;
        logic [31:0] exp_below;
        logic [31:0] exp_word3;
`ifdef DMEM_RANGE_CHECK_EN
        exp_err   = 1'b1;
        exp_below = 32'd0;
        exp_word3 = 32'd3;
`else
        exp_err   = 1'b0;
        exp_below = 32'd63;
        exp_word3 = 32'h000000AA;
`endif
        do_access(1'b0, 32'd1024 + 32'd256, '0, lat, rd, er, bok);
        vectors += 3;
        if (lat != 3) begin miscompares++; $display("[TB] FAIL range_latency got %0d want 3", lat); end
        if (rd !== 32'd0) begin miscompares++; $display("[TB] FAIL range_high_rdata got %h want 0", rd); end
        if (er !== exp_err) begin miscompares++; $display("[TB] FAIL range_high_err got %b want %b", er, exp_err); end
        do_access(1'b0, 32'd1020, '0, lat, rd, er, bok);
        vectors += 2;
        if (rd !== exp_below) begin miscompares++; $display("[TB] FAIL range_low_rdata got %h want %h", rd, exp_below); end
        if (er !== exp_err) begin miscompares++; $display("[TB] FAIL range_low_err got %b want %b", er, exp_err); end
        do_access(1'b1, 32'd1024 + 32'd268, 32'h000000AA, lat, rd, er, bok);
        do_access(1'b0, 32'd1024 + 32'd12, '0, lat, rd, er, bok);
        vectors += 1;
        if (rd !== exp_word3) begin miscompares++; $display("[TB] FAIL range_store_word3 got %h want %h", rd, exp_word3); end
    endtask

    task automatic test_latched();
        int lat; logic [31:0] rd; logic er; logic bok;
        logic got = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'd1024 + 32'd36;
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_we    = 1'b1;
        req_addr  = 32'd1024 + 32'd40;
        req_wdata = 32'hFFFF;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                got = 1'b1;
                vectors += 1;
                if (resp_rdata !== 32'd9) begin miscompares++; $display("[TB] FAIL latched_rdata got %h want 9", resp_rdata); end
                break;
            end
        end
        vectors += 1;
        if (got !== 1'b1) begin miscompares++; $display("[TB] FAIL latched_response got %b want 1", got); end
        do_access(1'b0, 32'd1024 + 32'd40, '0, lat, rd, er, bok);
        vectors += 1;
        if (rd !== 32'd10) begin miscompares++; $display("[TB] FAIL latched_nostore got %h want a", rd); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store_load();
        test_back_to_back();
        test_reset_abort();
        test_range();
        test_latched();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_mem_stage.md
DATA_MEM_STAGE -- requirements
Module: data_mem_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 64, number of words; power of two, 2..4096.
REQ-003 SHALL have parameter BASE_ADDR, default 1024, byte address of word 0.
REQ-004 SHALL have parameter WAIT_CYC, default 2, access wait states; legal range 0..15.
REQ-005 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port req_valid  input  1  request present.
REQ-008 SHALL have port req_ready  output  1  block accepts a request this cycle.
REQ-009 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-010 SHALL have port req_addr  input  32  byte address.
REQ-011 SHALL have port req_wdata  input  DATA_W  store data.
REQ-012 SHALL have port resp_valid  output  1  one-cycle response strobe.
REQ-013 SHALL have port resp_rdata  output  DATA_W  load data; 0 for stores.
REQ-014 SHALL have port resp_err  output  1  address-range error, qualified by resp_valid.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-017 req_ready SHALL be 1 in IDLE only; a request is accepted on a rising edge with req_valid=1 and req_ready=1.
REQ-018 On accept, SHALL latch req_we, req_addr and req_wdata, load the wait counter with WAIT_CYC, and go to WAIT (WAIT_CYC>0) or RESP (WAIT_CYC=0).
REQ-019 In WAIT, SHALL decrement the counter each cycle and go to RESP on the edge where the counter reaches 0; WAIT therefore lasts exactly WAIT_CYC cycles.
REQ-020 On the edge entering RESP, SHALL perform the store, or capture the load data into the resp_rdata register.
REQ-021 In RESP, resp_valid SHALL be 1 for exactly one cycle; the next state SHALL be IDLE unconditionally, with no response backpressure.
REQ-022 Response latency SHALL be WAIT_CYC+1 cycles from the accept edge; throughput SHALL be one request per WAIT_CYC+2 cycles.
REQ-023 Word index SHALL be (req_addr - BASE_ADDR) >> 2; bits [1:0] SHALL be ignored, with no misalignment fault.
REQ-024 Outside RESP, resp_rdata and resp_err SHALL read 0.
REQ-025 req_valid, req_we, req_addr and req_wdata SHALL be ignored outside IDLE.

Reset
REQ-026 rst=1 SHALL immediately force IDLE, counter 0, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, busy 0.
REQ-027 rst=1 SHALL initialise memory word i to value i (zero-extended to DATA_W) for all i.
REQ-028 A reset during WAIT or RESP SHALL abort the access: no store is performed and no response is issued.

Configuration
REQ-029 Macro DMEM_RANGE_CHECK_EN SHALL select range checking.
REQ-030 With DMEM_RANGE_CHECK_EN defined: an address below BASE_ADDR or at/above BASE_ADDR+4*DEPTH SHALL suppress the store, return resp_rdata=0, and set resp_err=1 in RESP.
REQ-031 Without DMEM_RANGE_CHECK_EN: the index SHALL wrap to its low log2(DEPTH) bits and resp_err SHALL be tied to 0.

Verification
REQ-032 Reset, then load addr 1024+4*5 with WAIT_CYC=2 -> resp_valid exactly 3 cycles after accept, resp_rdata=5, resp_err=0.
REQ-033 Store 0xDEADBEEF to addr 1032, then load addr 1035 -> resp_rdata=0xDEADBEEF; busy high from accept through RESP.
REQ-034 req_valid held high continuously, WAIT_CYC=0 -> accepts every 2nd cycle; resp_valid 1 cycle after each accept.
REQ-035 Assert rst 1 cycle after accepting a store of 0x1234 to addr 1024 -> no resp_valid; subsequent load of addr 1024 returns 0.
REQ-036 Load addr 1024+4*64 -> with DMEM_RANGE_CHECK_EN: resp_err=1, rdata 0; without: rdata 0, resp_err=0 (wraps to word 0).
REQ-037 Change req_addr and req_we during WAIT -> response still reflects the latched request.
